// File: rtl/dtcm_port_arbiter_if.sv
// Requester-side bundle for one DTCM access port (core or AXI path).
// The requester drives master; the arbiter consumes slave.
interface dtcm_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req;
    logic                    rd0_wr1;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH/8-1:0] byte_strobe;
    logic [DATA_WIDTH-1:0]   write_data;
    logic                    gnt;
    logic                    ack;
    logic [DATA_WIDTH-1:0]   read_data;

    modport master (
        output req, rd0_wr1, addr, byte_strobe, write_data,
        input  gnt, ack, read_data
    );

    modport slave (
        input  req, rd0_wr1, addr, byte_strobe, write_data,
        output gnt, ack, read_data
    );
endinterface

// File: rtl/dtcm_port_arbiter.sv
// Single-port DTCM SRAM arbiter: core has default priority, a starvation
// counter forces an AXI win after STARVE_LIMIT lost cycles.
module dtcm_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_AW       = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    dtcm_port_arbiter_if.slave      core,
    dtcm_port_arbiter_if.slave      axi,
    output logic                    mem_cs,
    output logic                    mem_we,
    output logic [MEM_AW-1:0]       mem_addr,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;
    logic          axi_win;
    logic          core_win;
    logic          rd_owner;
    logic          rd_is_read;
    logic          core_ack_q;
    logic          axi_ack_q;

    // Grants are gated by reset so nothing reaches the SRAM while held.
    always_comb begin
        axi_win  = ARESETn && axi.req &&
                   (!core.req || starve_cnt >= LIMIT);
        core_win = ARESETn && core.req && !axi_win;
    end

    assign axi.gnt  = axi_win;
    assign core.gnt = core_win;

    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        unique case (1'b1)
            axi_win: begin
                mem_cs    = 1'b1;
                mem_we    = axi.rd0_wr1;
                mem_addr  = axi.addr[MEM_AW+1:2];
                mem_be    = axi.rd0_wr1 ? axi.byte_strobe : '1;
                mem_wdata = axi.write_data;
            end
            core_win: begin
                mem_cs    = 1'b1;
                mem_we    = core.rd0_wr1;
                mem_addr  = core.addr[MEM_AW+1:2];
                mem_be    = core.rd0_wr1 ? core.byte_strobe : '1;
                mem_wdata = core.write_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            starve_cnt <= '0;
        end else if (!axi.req || axi_win) begin
            starve_cnt <= '0;
        end else if (starve_cnt < LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            core_ack_q <= 1'b0;
            axi_ack_q  <= 1'b0;
            rd_owner   <= 1'b0;
            rd_is_read <= 1'b0;
        end else begin
            core_ack_q <= core_win;
            axi_ack_q  <= axi_win;
            rd_owner   <= axi_win;
            rd_is_read <= !mem_we;
        end
    end

    assign core.ack = core_ack_q;
    assign axi.ack  = axi_ack_q;

    assign core.read_data = (core_ack_q && rd_is_read) ? mem_rdata : '0;
    assign axi.read_data  = (axi_ack_q && rd_is_read) ? mem_rdata : '0;

    // Address bits outside the word index are decoded upstream.
    logic unused_bits;
    assign unused_bits = ^{core.addr, axi.addr, rd_owner};
endmodule

// File: tb/tb_dtcm_port_arbiter.sv
// Bench for dtcm_port_arbiter: directed vector table, then random traffic
// against a reference model for STARVE_LIMIT=4 and STARVE_LIMIT=0 copies.
module tb_dtcm_port_arbiter;
    logic ACLK;
    logic rst_n;

    logic        creq, cwr, areq, awr;
    logic [31:0] caddr, cwd, aaddr, awd;
    logic [3:0]  cbe, abe;

    dtcm_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) c_if ();
    dtcm_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) a_if ();
    dtcm_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) c0_if ();
    dtcm_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) a0_if ();

    assign c_if.req = creq;          assign c0_if.req = creq;
    assign c_if.rd0_wr1 = cwr;       assign c0_if.rd0_wr1 = cwr;
    assign c_if.addr = caddr;        assign c0_if.addr = caddr;
    assign c_if.byte_strobe = cbe;   assign c0_if.byte_strobe = cbe;
    assign c_if.write_data = cwd;    assign c0_if.write_data = cwd;
    assign a_if.req = areq;          assign a0_if.req = areq;
    assign a_if.rd0_wr1 = awr;       assign a0_if.rd0_wr1 = awr;
    assign a_if.addr = aaddr;        assign a0_if.addr = aaddr;
    assign a_if.byte_strobe = abe;   assign a0_if.byte_strobe = abe;
    assign a_if.write_data = awd;    assign a0_if.write_data = awd;

    logic        mcs[2];
    logic        mwe[2];
    logic [11:0] maddr[2];
    logic [3:0]  mbe[2];
    logic [31:0] mwd[2];
    logic [31:0] mrd[2];

    dtcm_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(12), .STARVE_LIMIT(4)) dut (
        .ACLK(ACLK), .ARESETn(rst_n), .core(c_if), .axi(a_if),
        .mem_cs(mcs[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]),
        .mem_be(mbe[0]), .mem_wdata(mwd[0]), .mem_rdata(mrd[0])
    );

    dtcm_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(12), .STARVE_LIMIT(0)) dut0 (
        .ACLK(ACLK), .ARESETn(rst_n), .core(c0_if), .axi(a0_if),
        .mem_cs(mcs[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]),
        .mem_be(mbe[1]), .mem_wdata(mwd[1]), .mem_rdata(mrd[1])
    );

    logic        o_cg[2], o_ag[2], o_ca[2], o_aa[2];
    logic [31:0] o_crd[2], o_ard[2];
    assign o_cg[0] = c_if.gnt;        assign o_cg[1] = c0_if.gnt;
    assign o_ag[0] = a_if.gnt;        assign o_ag[1] = a0_if.gnt;
    assign o_ca[0] = c_if.ack;        assign o_ca[1] = c0_if.ack;
    assign o_aa[0] = a_if.ack;        assign o_aa[1] = a0_if.ack;
    assign o_crd[0] = c_if.read_data; assign o_crd[1] = c0_if.read_data;
    assign o_ard[0] = a_if.read_data; assign o_ard[1] = a0_if.read_data;

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    function automatic logic [31:0] init_word(int i);
        return (i == 4) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(i);
    endfunction

    // SRAM behaviour: one-cycle read latency, byte-masked writes.
    logic [31:0] sram[2][4096];
    always @(posedge ACLK) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                for (int i = 0; i < 4096; i++) sram[g][i] <= init_word(i);
                mrd[g] <= '0;
            end else if (mcs[g]) begin
                if (mwe[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (mbe[g][b]) sram[g][maddr[g]][8*b +: 8] <= mwd[g][8*b +: 8];
                end else begin
                    mrd[g] <= sram[g][maddr[g]];
                end
            end
        end
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state, one slot per DUT copy.
    int          m_cnt[2];
    logic        m_ack_c[2], m_ack_a[2];
    logic [31:0] m_rd_c[2], m_rd_a[2];
    logic [31:0] refm[2][4096];
    logic        eg_c[2], eg_a[2];

    function automatic int lim_of(int d);
        return (d == 0) ? 4 : 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0;
            m_ack_c[d] = 1'b0; m_ack_a[d] = 1'b0;
            m_rd_c[d] = '0; m_rd_a[d] = '0;
            eg_c[d] = 1'b0; eg_a[d] = 1'b0;
            for (int i = 0; i < 4096; i++) refm[d][i] = init_word(i);
        end
    endtask

    task automatic eval();
        logic        g, wr;
        logic [31:0] ad, wd;
        logic [3:0]  be;
        @(negedge ACLK);
        for (int d = 0; d < 2; d++) begin
            eg_a[d] = rst_n && areq && (!creq || m_cnt[d] >= lim_of(d));
            eg_c[d] = rst_n && creq && !eg_a[d];
            g  = eg_a[d] || eg_c[d];
            wr = eg_a[d] ? awr : cwr;
            ad = eg_a[d] ? aaddr : caddr;
            wd = eg_a[d] ? awd : cwd;
            be = eg_a[d] ? abe : cbe;
            chk($sformatf("d%0d core_gnt", d), o_cg[d], eg_c[d]);
            chk($sformatf("d%0d axi_gnt", d), o_ag[d], eg_a[d]);
            chk($sformatf("d%0d mem_cs", d), mcs[d], g);
            chk($sformatf("d%0d mem_we", d), mwe[d], g && wr);
            chk($sformatf("d%0d mem_addr", d), maddr[d], g ? ad[13:2] : 12'h0);
            chk($sformatf("d%0d mem_be", d), mbe[d], g ? (wr ? be : 4'hF) : 4'h0);
            chk($sformatf("d%0d mem_wdata", d), mwd[d], g ? wd : 32'h0);
            chk($sformatf("d%0d core_ack", d), o_ca[d], m_ack_c[d]);
            chk($sformatf("d%0d axi_ack", d), o_aa[d], m_ack_a[d]);
            chk($sformatf("d%0d core_rdata", d), o_crd[d], m_rd_c[d]);
            chk($sformatf("d%0d axi_rdata", d), o_ard[d], m_rd_a[d]);
        end
    endtask

    task automatic adv();
        logic        g, wr;
        logic [31:0] ad, wd, rv;
        logic [3:0]  be;
        @(posedge ACLK);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                g  = eg_a[d] || eg_c[d];
                wr = eg_a[d] ? awr : cwr;
                ad = eg_a[d] ? aaddr : caddr;
                wd = eg_a[d] ? awd : cwd;
                be = eg_a[d] ? abe : cbe;
                rv = (g && !wr) ? refm[d][ad[13:2]] : 32'h0;
                m_ack_c[d] = eg_c[d];
                m_ack_a[d] = eg_a[d];
                m_rd_c[d] = eg_c[d] ? rv : 32'h0;
                m_rd_a[d] = eg_a[d] ? rv : 32'h0;
                if (g && wr)
                    for (int b = 0; b < 4; b++)
                        if (be[b]) refm[d][ad[13:2]][8*b +: 8] = wd[8*b +: 8];
                if (!areq || eg_a[d]) m_cnt[d] = 0;
                else if (m_cnt[d] < lim_of(d)) m_cnt[d]++;
            end
        end
        #1;
    endtask

    typedef struct {
        logic cr, cw; logic [31:0] ca; logic [3:0] cb; logic [31:0] cd;
        logic ar, aw; logic [31:0] aa; logic [3:0] ab; logic [31:0] ad;
        logic ecg, eag; logic [11:0] ema; logic ewe; logic [3:0] ebe;
        logic eca, eaa; logic [31:0] ecd, ead; int ecnt;
    } vec_t;

    vec_t tbl[17];

    task automatic drive(logic cr, logic cw, logic [31:0] ca, logic [3:0] cb, logic [31:0] cd,
                         logic ar, logic aw, logic [31:0] aa, logic [3:0] ab, logic [31:0] ad);
        creq = cr; cwr = cw; caddr = ca; cbe = cb; cwd = cd;
        areq = ar; awr = aw; aaddr = aa; abe = ab; awd = ad;
    endtask

    initial begin
        //           core: req wr addr be data | axi: req wr addr be data | gc ga maddr we be | cack aack crd ard | cnt
        tbl[0]  = '{1,0,32'h10,4'h0,0, 0,0,0,4'h0,0,              1,0,12'd4,0,4'hF, 0,0,0,0,                       0};
        tbl[1]  = '{0,0,0,4'h0,0,      0,0,0,4'h0,0,              0,0,12'd0,0,4'h0, 1,0,32'hDEADBEEF,0,            0};
        tbl[2]  = '{0,0,0,4'h0,0,      1,1,32'h8,4'h3,32'h12345678, 0,1,12'd2,1,4'h3, 0,0,0,0,                     0};
        tbl[3]  = '{0,0,0,4'h0,0,      0,0,0,4'h0,0,              0,0,12'd0,0,4'h0, 0,1,0,0,                       0};
        tbl[4]  = '{1,0,32'h10,4'h0,0, 1,0,32'h8,4'h0,0,          1,0,12'd4,0,4'hF, 0,0,0,0,                       0};
        tbl[5]  = '{1,0,32'h10,4'h0,0, 1,0,32'h8,4'h0,0,          1,0,12'd4,0,4'hF, 1,0,32'hDEADBEEF,0,            1};
        tbl[6]  = '{1,0,32'h10,4'h0,0, 1,0,32'h8,4'h0,0,          1,0,12'd4,0,4'hF, 1,0,32'hDEADBEEF,0,            2};
        tbl[7]  = '{1,0,32'h10,4'h0,0, 1,0,32'h8,4'h0,0,          1,0,12'd4,0,4'hF, 1,0,32'hDEADBEEF,0,            3};
        tbl[8]  = '{1,0,32'h10,4'h0,0, 1,0,32'h8,4'h0,0,          0,1,12'd2,0,4'hF, 1,0,32'hDEADBEEF,0,            4};
        tbl[9]  = '{1,0,32'h10,4'h0,0, 0,0,0,4'h0,0,              1,0,12'd4,0,4'hF, 0,1,0,32'hA0005678,            0};
        tbl[10] = '{0,0,0,4'h0,0,      0,0,0,4'h0,0,              0,0,12'd0,0,4'h0, 1,0,32'hDEADBEEF,0,            0};
        tbl[11] = '{1,0,32'h10,4'h0,0, 0,0,0,4'h0,0,              1,0,12'd4,0,4'hF, 0,0,0,0,                       0};
        tbl[12] = '{0,0,0,4'h0,0,      1,0,32'h8,4'h0,0,          0,1,12'd2,0,4'hF, 1,0,32'hDEADBEEF,0,            0};
        tbl[13] = '{1,1,32'h10,4'hF,32'h55AA55AA, 0,0,0,4'h0,0,   1,0,12'd4,1,4'hF, 0,1,0,32'hA0005678,            0};
        tbl[14] = '{0,0,0,4'h0,0,      0,0,0,4'h0,0,              0,0,12'd0,0,4'h0, 1,0,0,0,                       0};
        tbl[15] = '{1,0,32'h10,4'h0,0, 0,0,0,4'h0,0,              1,0,12'd4,0,4'hF, 0,0,0,0,                       0};
        tbl[16] = '{0,0,0,4'h0,0,      0,0,0,4'h0,0,              0,0,12'd0,0,4'h0, 1,0,32'h55AA55AA,0,            0};

        rst_n = 1'b0;
        drive(0,0,0,0,0, 0,0,0,0,0);
        model_reset();
        repeat (2) begin
            eval();
            chk("reset starve_cnt", dut.starve_cnt, 0);
            adv();
        end
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cb, tbl[i].cd,
                  tbl[i].ar, tbl[i].aw, tbl[i].aa, tbl[i].ab, tbl[i].ad);
            eval();
            chk($sformatf("v%0d core_gnt", i), c_if.gnt, tbl[i].ecg);
            chk($sformatf("v%0d axi_gnt", i), a_if.gnt, tbl[i].eag);
            chk($sformatf("v%0d mem_addr", i), maddr[0], tbl[i].ema);
            chk($sformatf("v%0d mem_we", i), mwe[0], tbl[i].ewe);
            chk($sformatf("v%0d mem_be", i), mbe[0], tbl[i].ebe);
            chk($sformatf("v%0d core_ack", i), c_if.ack, tbl[i].eca);
            chk($sformatf("v%0d axi_ack", i), a_if.ack, tbl[i].eaa);
            chk($sformatf("v%0d core_rdata", i), c_if.read_data, tbl[i].ecd);
            chk($sformatf("v%0d axi_rdata", i), a_if.read_data, tbl[i].ead);
            chk($sformatf("v%0d starve_cnt", i), dut.starve_cnt, tbl[i].ecnt);
            adv();
        end

        // Zero limit: AXI wins every cycle even with the core requesting.
        drive(1,0,32'h10,0,0, 1,0,32'h8,0,0);
        repeat (5) begin
            eval();
            chk("lim0 axi_gnt", a0_if.gnt, 1'b1);
            chk("lim0 core_gnt", c0_if.gnt, 1'b0);
            adv();
        end
        drive(0,0,0,0,0, 0,0,0,0,0);
        repeat (2) begin eval(); adv(); end

        // Reset lands in the ack cycle of a granted read.
        drive(1,0,32'h10,0,0, 0,0,0,0,0);
        eval();
        adv();
        rst_n = 1'b0;
        model_reset();
        drive(1,0,32'h10,0,0, 1,0,32'h8,0,0);
        repeat (2) begin
            eval();
            chk("rst core_ack", c_if.ack, 1'b0);
            chk("rst axi_ack", a_if.ack, 1'b0);
            chk("rst core_gnt", c_if.gnt, 1'b0);
            chk("rst axi_gnt", a_if.gnt, 1'b0);
            chk("rst mem_cs", mcs[0], 1'b0);
            adv();
        end
        rst_n = 1'b1;
        drive(1,0,32'h10,0,0, 0,0,0,0,0);
        eval();
        chk("post-rst core_gnt", c_if.gnt, 1'b1);
        chk("post-rst mem_addr", maddr[0], 12'd4);
        adv();
        drive(0,0,0,0,0, 0,0,0,0,0);
        eval();
        chk("post-rst core_ack", c_if.ack, 1'b1);
        chk("post-rst core_rdata", c_if.read_data, 32'hDEADBEEF);
        chk("post-rst axi_ack", a_if.ack, 1'b0);
        adv();

        // Random traffic; a request is held until the limit-4 copy grants it.
        for (int n = 0; n < 400; n++) begin
            if (!creq || eg_c[0]) begin
                creq = ($urandom_range(0, 3) != 0);
                cwr = $urandom_range(0, 1) == 1;
                caddr = $urandom & 32'hFFFF_C03F;
                cbe = 4'($urandom);
                cwd = $urandom;
            end
            if (!areq || eg_a[0]) begin
                areq = $urandom_range(0, 1) == 1;
                awr = $urandom_range(0, 1) == 1;
                aaddr = $urandom & 32'hFFFF_C03F;
                abe = 4'($urandom);
                awd = $urandom;
            end
            eval();
            adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
